// File: rtl/sha_block_sequencer.sv
// sha_block_sequencer
// Queues 512-bit message blocks from the UART input handler, issues them one
// at a time to the SHA-256 compression core with IV/chaining selection,
// counts the blocks of each message and hands the final digest downstream
// over a valid/ready handshake. A watchdog traps a core that never answers.
module sha_block_sequencer #(
    parameter int DEPTH        = 2,
    parameter int CNT_W        = 16,
    parameter int CORE_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [511:0]     blk_data,
    input  logic             blk_dv,
    input  logic             blk_last,
    output logic [511:0]     core_block,
    output logic             core_start,
    output logic             core_init,
    input  logic             core_done,
    input  logic [255:0]     core_digest,
    output logic [255:0]     dig_data,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count,
    output logic             ovf,
    output logic             err
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(CORE_TIMEOUT + 1);
    localparam int EW  = 513;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_first;
    logic              r_last;
    logic [WDW-1:0]    r_wd;
    logic [511:0]      r_core_block;
    logic              r_core_start;
    logic              r_core_init;
    logic [255:0]      r_dig_data;
    logic              r_dig_valid;
    logic [CNT_W-1:0]  r_blk_count;
    logic              r_err;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [EW-1:0]     w_head;

    // The FSM pops only from IDLE; a full FIFO still accepts a push when the
    // head leaves in the same cycle, so no slot is ever lost to that race.
    assign w_empty = (r_count == CW'(0));
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_push  = blk_dv && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    assign core_block = r_core_block;
    assign core_start = r_core_start;
    assign core_init  = r_core_init;
    assign dig_data   = r_dig_data;
    assign dig_valid  = r_dig_valid;
    assign blk_count  = r_blk_count;
    assign ovf        = r_ovf;
    assign err        = r_err;
    // Derived from registers only, so it carries no input-to-output path.
    assign busy       = (r_state != S_IDLE) || !w_empty;

    // FIFO storage; occupancy gates every read, so contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {blk_last, blk_data};
        end
    end

    // FIFO pointers, occupancy count and sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (blk_dv && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Block sequencing FSM with registered core and digest outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_first      <= 1'b1;
            r_last       <= 1'b0;
            r_wd         <= '0;
            r_core_block <= '0;
            r_core_start <= 1'b0;
            r_core_init  <= 1'b1;
            r_dig_data   <= '0;
            r_dig_valid  <= 1'b0;
            r_blk_count  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_core_block <= w_head[511:0];
                        r_last       <= w_head[512];
                        if (r_first) begin
                            r_blk_count <= '0;
                        end
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_core_start <= 1'b1;
                    r_core_init  <= r_first;
                    r_wd         <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_blk_count <= r_blk_count + CNT_W'(1);
                        if (r_last) begin
                            r_dig_data <= core_digest;
                            r_state    <= S_OUT;
                        end else begin
                            r_first <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (r_wd == WDW'(CORE_TIMEOUT - 1)) begin
                        r_wd    <= WDW'(CORE_TIMEOUT);
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                S_OUT: begin
                    // Raise valid one cycle after entering OUT, then hold
                    // until the downstream handler takes the digest.
                    if (!r_dig_valid) begin
                        r_dig_valid <= 1'b1;
                    end else if (dig_ready) begin
                        r_dig_valid <= 1'b0;
                        r_first     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    // Corrupted state encoding is treated like a core fault.
                    r_err   <= 1'b1;
                    r_state <= S_ERR;
                end
            endcase
        end
    end

endmodule
